// File: rtl/if_id_pipe_reg_if.sv
// IF/ID boundary bundle: fetch-side inputs, decode-side outputs, hazard controls, debug counters.
// Latency: none (wiring only).
// Backpressure: stall/flush travel from the hazard unit alongside the fetch payload.
interface if_id_pipe_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic [PC_W-1:0]    in_pc_added;
    logic [INSTR_W-1:0] in_instruction;
    logic               stall;
    logic               flush;
    logic               cnt_clr;
    logic               out_valid;
    logic [PC_W-1:0]    out_pc_added;
    logic [INSTR_W-1:0] out_instruction;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    // Driver side (fetch + hazard unit), observes decode outputs.
    modport master (
        output in_valid, in_pc_added, in_instruction, stall, flush, cnt_clr,
        input  out_valid, out_pc_added, out_instruction, stall_cnt, flush_cnt
    );

    // Pipeline register side.
    modport slave (
        input  in_valid, in_pc_added, in_instruction, stall, flush, cnt_clr,
        output out_valid, out_pc_added, out_instruction, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid bit, hold, bubble insertion and saturating hazard counters.
// Latency: 1 cycle on a load; all outputs are registered.
// Backpressure: stall holds contents, flush squashes to a bubble (flush wins over stall).
module if_id_pipe_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input logic           clk,
    input logic           rst_n,
    if_id_pipe_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               valid_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;

    // A stall only counts when no flush overrides it on the same edge.
    logic stall_eff;
    assign stall_eff = bus.stall & ~bus.flush;

    // Data path: flush > stall > load; bubbles always carry pc=0 and the NOP encoding,
    // and in_* is only captured on a valid load so X on an idle fetch never leaks through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (!bus.stall) begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                pc_q    <= bus.in_pc_added;
                instr_q <= bus.in_instruction;
            end else begin
                pc_q    <= '0;
                instr_q <= NOP_INSTR;
            end
        end
    end

    // Saturating event counters; clear wins over an increment on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_eff && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bus.flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_pc_added    = pc_q;
    assign bus.out_instruction = instr_q;
    assign bus.stall_cnt       = stall_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: three instances (default, all-ones NOP, 3-bit counters) on shared stimulus.
// Latency: expects registered outputs one edge after each input set.
// Backpressure: stall/flush driven directed, then randomly.
module tb_if_id_pipe_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc_added = '0;
    logic [31:0] in_instruction = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_pipe_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(16)) bus_a ();
    if_id_pipe_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(16)) bus_b ();
    if_id_pipe_reg_if #(.PC_W(32), .INSTR_W(32), .CNT_W(3))  bus_c ();

    assign bus_a.in_valid = in_valid;   assign bus_b.in_valid = in_valid;   assign bus_c.in_valid = in_valid;
    assign bus_a.in_pc_added = in_pc_added; assign bus_b.in_pc_added = in_pc_added; assign bus_c.in_pc_added = in_pc_added;
    assign bus_a.in_instruction = in_instruction; assign bus_b.in_instruction = in_instruction; assign bus_c.in_instruction = in_instruction;
    assign bus_a.stall = stall;   assign bus_b.stall = stall;   assign bus_c.stall = stall;
    assign bus_a.flush = flush;   assign bus_b.flush = flush;   assign bus_c.flush = flush;
    assign bus_a.cnt_clr = cnt_clr; assign bus_b.cnt_clr = cnt_clr; assign bus_c.cnt_clr = cnt_clr;

    if_id_pipe_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0000_0000), .CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    if_id_pipe_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'hFFFF_FFFF), .CNT_W(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    if_id_pipe_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0000_0000), .CNT_W(3))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    // Observed outputs gathered per instance so the model can be compared in a loop.
    logic        o_v[3];
    logic [31:0] o_pc[3];
    logic [31:0] o_ins[3];
    logic [31:0] o_sc[3];
    logic [31:0] o_fc[3];
    assign o_v[0] = bus_a.out_valid; assign o_pc[0] = bus_a.out_pc_added; assign o_ins[0] = bus_a.out_instruction;
    assign o_v[1] = bus_b.out_valid; assign o_pc[1] = bus_b.out_pc_added; assign o_ins[1] = bus_b.out_instruction;
    assign o_v[2] = bus_c.out_valid; assign o_pc[2] = bus_c.out_pc_added; assign o_ins[2] = bus_c.out_instruction;
    assign o_sc[0] = {16'b0, bus_a.stall_cnt}; assign o_fc[0] = {16'b0, bus_a.flush_cnt};
    assign o_sc[1] = {16'b0, bus_b.stall_cnt}; assign o_fc[1] = {16'b0, bus_b.flush_cnt};
    assign o_sc[2] = {29'b0, bus_c.stall_cnt}; assign o_fc[2] = {29'b0, bus_c.flush_cnt};

    // Reference model: what decode should be holding and how many events have been seen.
    logic [31:0] m_v[3];
    logic [31:0] m_pc[3];
    logic [31:0] m_ins[3];
    int          m_sc[3];
    int          m_fc[3];

    function automatic logic [31:0] nop_of(int i);
        return (i == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
    endfunction

    function automatic int max_of(int i);
        return (i == 2) ? 7 : 65535;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_pc[i] = 0; m_ins[i] = nop_of(i); m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                m_v[i] = 0; m_pc[i] = 0; m_ins[i] = nop_of(i);
            end else if (!stall) begin
                m_v[i]   = {31'b0, in_valid};
                m_pc[i]  = in_valid ? in_pc_added : 32'h0;
                m_ins[i] = in_valid ? in_instruction : nop_of(i);
            end
            if (cnt_clr) begin
                m_sc[i] = 0; m_fc[i] = 0;
            end else if (flush) begin
                m_fc[i] = (m_fc[i] + 1 > max_of(i)) ? max_of(i) : m_fc[i] + 1;
            end else if (stall) begin
                m_sc[i] = (m_sc[i] + 1 > max_of(i)) ? max_of(i) : m_sc[i] + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.d%0d.valid", tag, i), {31'b0, o_v[i]}, m_v[i]);
            chk($sformatf("%s.d%0d.pc", tag, i), o_pc[i], m_pc[i]);
            chk($sformatf("%s.d%0d.instr", tag, i), o_ins[i], m_ins[i]);
            chk($sformatf("%s.d%0d.stall_cnt", tag, i), o_sc[i], m_sc[i]);
            chk($sformatf("%s.d%0d.flush_cnt", tag, i), o_fc[i], m_fc[i]);
        end
    endtask

    // One clock: inputs are already settled; outputs are sampled on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic s, input logic f, input logic c);
        in_valid = v; in_pc_added = pc; in_instruction = ins; stall = s; flush = f; cnt_clr = c;
    endtask

    initial begin
        // Reset held for 3 cycles.
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset.instr_zero", o_ins[0], 32'h0000_0000);
        chk("reset.valid_zero", {31'b0, o_v[0]}, 32'h0);
        rst_n = 1'b1;

        // Streaming: each pair visible one edge later.
        drive(1'b1, 32'h4, 32'h2008_0005, 1'b0, 1'b0, 1'b0);
        tick("stream0");
        chk("stream0.pc_lit", o_pc[0], 32'h4);
        drive(1'b1, 32'h8, 32'h2009_0003, 1'b0, 1'b0, 1'b0);
        tick("stream1");

        // Stall for 3 cycles while the fetch side moves on.
        drive(1'b1, 32'hC, 32'h0109_5020, 1'b1, 1'b0, 1'b0);
        repeat (3) tick("stall");
        chk("stall.pc_held", o_pc[0], 32'h8);
        chk("stall.instr_held", o_ins[0], 32'h2009_0003);
        chk("stall.cnt3", o_sc[0], 32'd3);
        stall = 1'b0;
        tick("stall_release");
        chk("release.pc", o_pc[0], 32'hC);

        // Flush together with stall: bubble, flush counted, stall not.
        drive(1'b1, 32'h10, 32'hAC0A_0000, 1'b1, 1'b1, 1'b0);
        tick("flush");
        chk("flush.nop_a", o_ins[0], 32'h0000_0000);
        chk("flush.nop_b", o_ins[1], 32'hFFFF_FFFF);
        chk("flush.fcnt", o_fc[0], 32'd1);
        chk("flush.scnt", o_sc[0], 32'd3);

        // Invalid fetch must not capture the payload.
        drive(1'b0, 32'h14, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        tick("invalid");
        chk("invalid.pc", o_pc[1], 32'h0);
        chk("invalid.instr_b", o_ins[1], 32'hFFFF_FFFF);

        // Async reset while holding valid data under stall.
        drive(1'b1, 32'h18, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        tick("preload");
        stall = 1'b1;
        tick("hold");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.valid", {31'b0, o_v[0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the 3-bit stall counter, then clear beside a stall.
        drive(1'b1, 32'h1C, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        repeat (10) tick("sat");
        chk("sat.c7", o_sc[2], 32'd7);
        chk("sat.a10", o_sc[0], 32'd10);
        cnt_clr = 1'b1;
        tick("clr");
        chk("clr.c0", o_sc[2], 32'd0);
        chk("clr.a0", o_sc[0], 32'd0);
        cnt_clr = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 47) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
